// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the core's load/store port. Accepts one request
// at a time, waits a fixed number of cycles, performs the access on an
// internal word-organised RAM, then presents a registered response until the
// core takes it. Misaligned accesses and illegal size codes return an error
// and never write the RAM.
module data_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam int         AW       = DEPTH_LOG2 + 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Returns 1 for misaligned accesses and size codes illegal for the direction.
    function automatic logic access_error(input logic wen, input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic e;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = lo[0];
            3'b010:  e = (lo != 2'b00);
            3'b100:  e = wen;
            3'b101:  e = wen | lo[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Picks the addressed byte/halfword out of a word and extends it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Overlays the store data onto the addressed lanes, keeping the other bytes.
    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] m;
        m = word;
        case (f3)
            3'b000:  m[{lo, 3'b000} +: 8] = wd[7:0];
            3'b001:  m[{lo[1], 4'b0000} +: 16] = wd[15:0];
            3'b010:  m = wd;
            default: m = word;
        endcase
        return m;
    endfunction

    logic [31:0]           ram_q [0:DEPTH-1];

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [2:0]            f3_q, f3_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [DEPTH_LOG2-1:0] idx_s;
    logic [31:0]           word_s;
    logic                  acc_err_s;
    logic                  we_s;
    logic                  unused_s;

    assign idx_s     = addr_q[AW-1:2];
    assign word_s    = ram_q[idx_s];
    assign acc_err_s = access_error(wen_q, f3_q, addr_q[1:0]);
    // Upper address bits alias and are deliberately dropped.
    assign unused_s  = ^req_addr[31:AW];

    // Next-state, capture, and access/response computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[AW-1:0];
                    wen_d   = req_wen;
                    f3_d    = req_funct3;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    // Always pass through WAIT so the response rises exactly
                    // LATENCY edges after acceptance, including LATENCY=1.
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    err_d   = acc_err_s;
                    rdata_d = (acc_err_s | wen_q) ? 32'd0
                                                  : load_extract(f3_q, addr_q[1:0], word_s);
                    we_s    = wen_q & ~acc_err_s;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM write port; contents survive reset, but a reset edge blocks the commit.
    always_ff @(posedge clk) begin
        if (we_s && !rst) begin
            ram_q[idx_s] <= store_merge(f3_q, addr_q[1:0], word_s, wdata_q);
        end
    end

    assign req_ready = (state_q == ST_IDLE) & ~rst;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances with LATENCY 2, 1, 15
// and 4 cover extraction, store merge, errors, back-pressure, aliasing,
// latency and reset during a pending store.
module tb_data_mem_responder;

    localparam int LATS [4] = '{2, 1, 15, 4};

    logic        clk;
    logic [3:0]  rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic [3:0]  rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata [4];
    logic [3:0]  rsp_err;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LATS[g])) dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr),
            .req_wen    (req_wen),
            .req_funct3 (req_funct3),
            .req_wdata  (req_wdata),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int k, input logic [31:0] v);
        case (k)
            0:       g_dut[0].dut.ram_q[16] = v;
            1:       g_dut[1].dut.ram_q[16] = v;
            2:       g_dut[2].dut.ram_q[16] = v;
            default: g_dut[3].dut.ram_q[16] = v;
        endcase
    endtask

    // One full transaction on instance k; hold = cycles of back-pressure.
    task automatic txn(input int k, input string tag, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int n;
        req_addr   = addr;
        req_wen    = wen;
        req_funct3 = f3;
        req_wdata  = wdata;
        req_valid[k] = 1'b1;
        rsp_ready  = (hold == 0);
        #1;
        chk({tag, "_req_ready"}, 32'(req_ready[k]), 32'd1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        req_addr   = ~addr;
        req_wen    = ~wen;
        req_funct3 = ~f3;
        req_wdata  = ~wdata;
        n = 0;
        while (!rsp_valid[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(LATS[k]));
        chk({tag, "_rdata"}, rsp_rdata[k], exp_rd);
        chk({tag, "_err"}, 32'(rsp_err[k]), 32'(exp_err));
        chk({tag, "_busy"}, 32'(req_ready[k]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid[k]), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata[k], exp_rd);
            chk({tag, "_hold_err"}, 32'(rsp_err[k]), 32'(exp_err));
            chk({tag, "_hold_busy"}, 32'(req_ready[k]), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_done_valid"}, 32'(rsp_valid[k]), 32'd0);
        chk({tag, "_done_ready"}, 32'(req_ready[k]), 32'd1);
    endtask

    initial begin
        rst        = 4'hF;
        req_valid  = 4'h0;
        req_addr   = 32'd0;
        req_wen    = 1'b0;
        req_funct3 = 3'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;

        // Reset behaviour
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        rst = 4'h0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'hF);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("post_rst_rsp_err", 32'(rsp_err), 32'h0);
        for (int k = 0; k < 4; k++) chk("post_rst_rdata", rsp_rdata[k], 32'd0);

        // Load extraction, LATENCY=2
        preload(0, 32'h8001_F07F);
        txn(0, "lw",  1'b0, 3'b010, 32'h40, 32'd0, 32'h8001_F07F, 1'b0, 0);
        txn(0, "lb0", 1'b0, 3'b000, 32'h40, 32'd0, 32'h0000_007F, 1'b0, 0);
        txn(0, "lb1", 1'b0, 3'b000, 32'h41, 32'd0, 32'hFFFF_FFF0, 1'b0, 0);
        txn(0, "lbu", 1'b0, 3'b100, 32'h41, 32'd0, 32'h0000_00F0, 1'b0, 0);
        txn(0, "lh",  1'b0, 3'b001, 32'h42, 32'd0, 32'hFFFF_8001, 1'b0, 0);
        txn(0, "lhu", 1'b0, 3'b101, 32'h42, 32'd0, 32'h0000_8001, 1'b0, 0);

        // Store merge
        preload(0, 32'h1122_3344);
        txn(0, "sb",    1'b1, 3'b000, 32'h41, 32'h0000_00AB, 32'd0, 1'b0, 0);
        txn(0, "sh",    1'b1, 3'b001, 32'h42, 32'h0000_CDEF, 32'd0, 1'b0, 0);
        txn(0, "merge", 1'b0, 3'b010, 32'h40, 32'd0, 32'hCDEF_AB44, 1'b0, 0);

        // Error cases leave the word untouched
        txn(0, "err_lh",  1'b0, 3'b001, 32'h41, 32'd0, 32'd0, 1'b1, 0);
        txn(0, "err_lw",  1'b0, 3'b010, 32'h42, 32'd0, 32'd0, 1'b1, 0);
        txn(0, "err_011", 1'b0, 3'b011, 32'h40, 32'd0, 32'd0, 1'b1, 0);
        txn(0, "err_sb4", 1'b1, 3'b100, 32'h40, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        txn(0, "err_sw_mis", 1'b1, 3'b010, 32'h41, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        txn(0, "after_err", 1'b0, 3'b010, 32'h40, 32'd0, 32'hCDEF_AB44, 1'b0, 0);

        // Back-pressure for 5 cycles
        txn(0, "bp", 1'b0, 3'b010, 32'h40, 32'd0, 32'hCDEF_AB44, 1'b0, 5);

        // Aliasing and latency sweep (LATENCY 2, 1, 15)
        for (int k = 0; k < 3; k++) begin
            txn(k, "alias_sw", 1'b1, 3'b010, 32'h0000_1040, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
            txn(k, "alias_lw", 1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
        end

        // Reset during a pending store, LATENCY=4
        preload(3, 32'hAAAA_AAAA);
        req_addr   = 32'h40;
        req_wen    = 1'b1;
        req_funct3 = 3'b010;
        req_wdata  = 32'h1234_5678;
        req_valid[3] = 1'b1;
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst[3] = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req_ready", 32'(req_ready[3]), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid[3]), 32'd0);
        rst[3] = 1'b0;
        #1;
        chk("midrst_after_ready", 32'(req_ready[3]), 32'd1);
        chk("midrst_after_valid", 32'(rsp_valid[3]), 32'd0);
        chk("midrst_after_rdata", rsp_rdata[3], 32'd0);
        chk("midrst_after_err", 32'(rsp_err[3]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", 32'(rsp_valid[3]), 32'd0);
        end
        txn(3, "midrst_lw", 1'b0, 3'b010, 32'h40, 32'd0, 32'hAAAA_AAAA, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
